// File: rtl/matrix_input_ctrl.sv
// Matrix entry controller: collects m x n dimensions, then feeds m*n elements (manual or random)
// to a storage block and waits for its completion pulse.
module matrix_input_ctrl #(
  parameter int unsigned MAX_DIM    = 5,
  parameter int unsigned ELEM_WIDTH = 8,
  parameter int unsigned ERR_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  rand_mode,
  input  logic                  confirm,
  input  logic                  finish,
  input  logic [ELEM_WIDTH-1:0] sw_val,
  input  logic [ELEM_WIDTH-1:0] rand_val,
  input  logic                  rand_valid,
  output logic                  rand_req,
  output logic                  store_wen,
  output logic [3:0]            store_m,
  output logic [3:0]            store_n,
  output logic [ELEM_WIDTH-1:0] store_elem,
  output logic                  store_elem_valid,
  input  logic                  store_input_done,
  output logic                  busy,
  output logic                  err,
  output logic                  done,
  output logic [2:0]            state,
  output logic [4:0]            elem_cnt
);

  localparam int unsigned ErrCntW = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StGetM = 3'd1,
    StGetN = 3'd2,
    StWen  = 3'd3,
    StElem = 3'd4,
    StWait = 3'd5,
    StDone = 3'd6,
    StErr  = 3'd7
  } state_e;

  state_e                state_q, state_d;
  logic                  rand_mode_q, rand_mode_d;
  logic [3:0]            store_m_q, store_m_d;
  logic [3:0]            store_n_q, store_n_d;
  logic [ELEM_WIDTH-1:0] store_elem_q, store_elem_d;
  logic                  store_wen_q, store_wen_d;
  logic                  elem_valid_q, elem_valid_d;
  logic                  rand_req_q, rand_req_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [4:0]            elem_cnt_q, elem_cnt_d;
  logic [ErrCntW-1:0]    err_cnt_q, err_cnt_d;
  logic                  err_ret_n_q, err_ret_n_d;

  logic                  dim_ok;
  logic                  issue;
  logic [4:0]            cnt_inc;
  logic [7:0]            mn;

  // Full-width compare so large switch values cannot alias into range.
  assign dim_ok  = (sw_val != '0) && (sw_val <= ELEM_WIDTH'(MAX_DIM));
  assign mn      = {4'b0, store_m_q} * {4'b0, store_n_q};
  assign cnt_inc = elem_cnt_q + 5'd1;
  assign issue   = rand_mode_q ? (rand_req_q && rand_valid) : confirm;

  always_comb begin
    state_d      = state_q;
    rand_mode_d  = rand_mode_q;
    store_m_d    = store_m_q;
    store_n_d    = store_n_q;
    store_elem_d = store_elem_q;
    elem_valid_d = 1'b0;
    elem_cnt_d   = elem_cnt_q;
    err_cnt_d    = err_cnt_q;
    err_ret_n_d  = err_ret_n_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          rand_mode_d = rand_mode;
          state_d     = StGetM;
        end
      end
      StGetM: begin
        if (confirm) begin
          if (dim_ok) begin
            store_m_d = sw_val[3:0];
            state_d   = StGetN;
          end else begin
            err_ret_n_d = 1'b0;
            err_cnt_d   = '0;
            state_d     = StErr;
          end
        end
      end
      StGetN: begin
        if (confirm) begin
          if (dim_ok) begin
            store_n_d = sw_val[3:0];
            state_d   = StWen;
          end else begin
            err_ret_n_d = 1'b1;
            err_cnt_d   = '0;
            state_d     = StErr;
          end
        end
      end
      StWen: begin
        elem_cnt_d = '0;
        state_d    = StElem;
      end
      StElem: begin
        if (issue) begin
          store_elem_d = rand_mode_q ? rand_val : sw_val;
          elem_valid_d = 1'b1;
          elem_cnt_d   = cnt_inc;
          if ({3'b0, cnt_inc} == mn) begin
            state_d = StWait;
          end else if (finish && !rand_mode_q) begin
            state_d = StDone;
          end
        end else if (finish && !rand_mode_q) begin
          state_d = StDone;
        end
      end
      StWait: begin
        if (store_input_done) state_d = StDone;
      end
      StDone: state_d = StIdle;
      StErr: begin
        if (err_cnt_q == ErrCntW'(ERR_CYCLES - 1)) begin
          state_d = err_ret_n_q ? StGetN : StGetM;
        end else begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Status outputs are registered copies of the next-state decode.
    store_wen_d = (state_d == StWen);
    err_d       = (state_d == StErr);
    done_d      = (state_d == StDone);
    busy_d      = (state_d != StIdle);
    rand_req_d  = (state_d == StElem) && rand_mode_d && ({3'b0, elem_cnt_d} < mn);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rand_mode_q  <= 1'b0;
      store_m_q    <= '0;
      store_n_q    <= '0;
      store_elem_q <= '0;
      store_wen_q  <= 1'b0;
      elem_valid_q <= 1'b0;
      rand_req_q   <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      elem_cnt_q   <= '0;
      err_cnt_q    <= '0;
      err_ret_n_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rand_mode_q  <= rand_mode_d;
      store_m_q    <= store_m_d;
      store_n_q    <= store_n_d;
      store_elem_q <= store_elem_d;
      store_wen_q  <= store_wen_d;
      elem_valid_q <= elem_valid_d;
      rand_req_q   <= rand_req_d;
      err_q        <= err_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      elem_cnt_q   <= elem_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_ret_n_q  <= err_ret_n_d;
    end
  end

  assign state            = state_q;
  assign rand_req         = rand_req_q;
  assign store_wen        = store_wen_q;
  assign store_m          = store_m_q;
  assign store_n          = store_n_q;
  assign store_elem       = store_elem_q;
  assign store_elem_valid = elem_valid_q;
  assign busy             = busy_q;
  assign err              = err_q;
  assign done             = done_q;
  assign elem_cnt         = elem_cnt_q;

endmodule

// File: tb/tb_matrix_input_ctrl.sv
// Directed bench for matrix_input_ctrl: manual entry, dimension errors, early finish,
// random fill and mid-entry reset.
module tb_matrix_input_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, rand_mode, confirm, finish, rand_valid, store_input_done;
  logic [7:0] sw_val, rand_val, store_elem;
  logic       rand_req, store_wen, store_elem_valid, busy, err, done;
  logic [3:0] store_m, store_n;
  logic [2:0] state;
  logic [4:0] elem_cnt;

  int checks = 0;
  int fails  = 0;
  int wen_seen = 0;
  int strobe_seen = 0;

  matrix_input_ctrl #(.MAX_DIM(5), .ELEM_WIDTH(8), .ERR_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rand_mode(rand_mode), .confirm(confirm),
    .finish(finish), .sw_val(sw_val), .rand_val(rand_val), .rand_valid(rand_valid),
    .rand_req(rand_req), .store_wen(store_wen), .store_m(store_m), .store_n(store_n),
    .store_elem(store_elem), .store_elem_valid(store_elem_valid),
    .store_input_done(store_input_done), .busy(busy), .err(err), .done(done),
    .state(state), .elem_cnt(elem_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (store_wen) wen_seen++;
    if (store_elem_valid) strobe_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 0; rand_mode = 0; confirm = 0; finish = 0;
    rand_valid = 0; store_input_done = 0; sw_val = 0; rand_val = 0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_confirm(input logic [7:0] v);
    sw_val = v; confirm = 1; tick(); confirm = 0;
  endtask

  task automatic begin_entry(input logic rm, input logic [7:0] m, input logic [7:0] n);
    rand_mode = rm; start = 1; tick(); start = 0; rand_mode = 0;
    pulse_confirm(m);
    pulse_confirm(n);
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state !== 3'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
    checks++;
    if ({busy, err, done, store_wen, store_elem_valid, rand_req, elem_cnt, store_m, store_n,
         store_elem} !== '0) begin
      fails++; $display("FAIL reset_outputs got nonzero, want all 0");
    end
  endtask

  task automatic test_manual();
    int w0, s0;
    do_reset();
    w0 = wen_seen; s0 = strobe_seen;
    start = 1; tick(); start = 0;
    checks++;
    if (state !== 3'd1 || busy !== 1'b1) begin
      fails++; $display("FAIL start_getm got state %0d busy %b want 1/1", state, busy);
    end
    pulse_confirm(8'd2);
    pulse_confirm(8'd3);
    checks++;
    if (state !== 3'd3 || store_wen !== 1'b1 || store_m !== 4'd2 || store_n !== 4'd3) begin
      fails++; $display("FAIL wen got st %0d wen %b m %0d n %0d want 3/1/2/3",
                        state, store_wen, store_m, store_n);
    end
    tick();
    checks++;
    if (state !== 3'd4 || store_wen !== 1'b0 || store_elem_valid !== 1'b0) begin
      fails++; $display("FAIL elem_entry got st %0d wen %b v %b want 4/0/0",
                        state, store_wen, store_elem_valid);
    end
    for (int i = 1; i <= 6; i++) begin
      pulse_confirm(8'(i));
      checks++;
      if (store_elem_valid !== 1'b1 || store_elem !== 8'(i) || elem_cnt !== 5'(i)) begin
        fails++; $display("FAIL manual_elem%0d got v %b e %0d c %0d want 1/%0d/%0d",
                          i, store_elem_valid, store_elem, elem_cnt, i, i);
      end
      tick();
    end
    checks++;
    if (state !== 3'd5) begin fails++; $display("FAIL manual_wait got %0d want 5", state); end
    tick(); tick();
    checks++;
    if (state !== 3'd5 || wen_seen - w0 !== 1 || strobe_seen - s0 !== 6) begin
      fails++; $display("FAIL manual_counts got st %0d wen %0d strb %0d want 5/1/6",
                        state, wen_seen - w0, strobe_seen - s0);
    end
    store_input_done = 1; tick(); store_input_done = 0;
    checks++;
    if (state !== 3'd6 || done !== 1'b1) begin
      fails++; $display("FAIL manual_done got st %0d done %b want 6/1", state, done);
    end
    tick();
    checks++;
    if (state !== 3'd0 || done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL manual_idle got st %0d done %b busy %b want 0/0/0",
                        state, done, busy);
    end
  endtask

  task automatic test_dim_error();
    logic [7:0] bad [2];
    bad[0] = 8'd0; bad[1] = 8'd6;
    do_reset();
    start = 1; tick(); start = 0;
    for (int b = 0; b < 2; b++) begin
      int hi = 0;
      pulse_confirm(bad[b]);
      for (int c = 0; c < 40 && err === 1'b1; c++) begin
        hi++;
        checks++;
        if (state !== 3'd7 || busy !== 1'b1) begin
          fails++; $display("FAIL err_state got st %0d busy %b want 7/1", state, busy);
        end
        tick();
      end
      checks++;
      if (hi !== 16) begin fails++; $display("FAIL err_len got %0d want 16", hi); end
      checks++;
      if (state !== 3'd1 || store_m !== 4'd0) begin
        fails++; $display("FAIL err_return got st %0d m %0d want 1/0", state, store_m);
      end
    end
    pulse_confirm(8'd1);
    pulse_confirm(8'd200);
    checks++;
    if (state !== 3'd7 || store_m !== 4'd1 || store_n !== 4'd0) begin
      fails++; $display("FAIL errn got st %0d m %0d n %0d want 7/1/0", state, store_m, store_n);
    end
    repeat (16) tick();
    checks++;
    if (state !== 3'd2 || err !== 1'b0) begin
      fails++; $display("FAIL errn_return got st %0d err %b want 2/0", state, err);
    end
  endtask

  task automatic test_confirm_finish();
    do_reset();
    begin_entry(1'b0, 8'd2, 8'd2);
    pulse_confirm(8'd7);
    checks++;
    if (store_elem_valid !== 1'b1 || store_elem !== 8'd7 || elem_cnt !== 5'd1) begin
      fails++; $display("FAIL cf_first got v %b e %0d c %0d want 1/7/1",
                        store_elem_valid, store_elem, elem_cnt);
    end
    tick();
    sw_val = 8'd9; confirm = 1; finish = 1; tick(); confirm = 0; finish = 0;
    checks++;
    if (store_elem_valid !== 1'b1 || store_elem !== 8'd9 || elem_cnt !== 5'd2 ||
        state !== 3'd6 || done !== 1'b1) begin
      fails++; $display("FAIL cf_second got v %b e %0d c %0d st %0d done %b want 1/9/2/6/1",
                        store_elem_valid, store_elem, elem_cnt, state, done);
    end
    tick();
    checks++;
    if (state !== 3'd0) begin fails++; $display("FAIL cf_idle got %0d want 0", state); end
  endtask

  task automatic test_random();
    int s0;
    int obs = 0;
    do_reset();
    begin_entry(1'b1, 8'd5, 8'd5);
    s0 = strobe_seen;
    checks++;
    if (state !== 3'd4 || rand_req !== 1'b1) begin
      fails++; $display("FAIL rand_req_on got st %0d req %b want 4/1", state, rand_req);
    end
    finish = 1; tick(); finish = 0;
    checks++;
    if (state !== 3'd4) begin fails++; $display("FAIL rand_finish got %0d want 4", state); end
    for (int k = 0; k < 80; k++) begin
      rand_valid = (k % 2 == 0);
      rand_val = 8'(8'h10 + obs + 1);
      tick();
      rand_valid = 0;
      if (store_elem_valid === 1'b1) begin
        obs++;
        checks++;
        if (store_elem !== 8'(8'h10 + obs)) begin
          fails++; $display("FAIL rand_val%0d got %0d want %0d", obs, store_elem, 8'h10 + obs);
        end
        if (obs == 25) begin
          checks++;
          if (rand_req !== 1'b0 || state !== 3'd5) begin
            fails++; $display("FAIL rand_last got req %b st %0d want 0/5", rand_req, state);
          end
        end
      end
    end
    tick();
    checks++;
    if (obs !== 25 || strobe_seen - s0 !== 25 || elem_cnt !== 5'd25 || rand_req !== 1'b0) begin
      fails++; $display("FAIL rand_count got obs %0d strb %0d c %0d req %b want 25/25/25/0",
                        obs, strobe_seen - s0, elem_cnt, rand_req);
    end
  endtask

  task automatic test_reset_mid();
    int s0, w0;
    do_reset();
    begin_entry(1'b0, 8'd2, 8'd3);
    for (int i = 0; i < 3; i++) pulse_confirm(8'(i + 4));
    rst_n = 0; tick(); rst_n = 1;
    checks++;
    if (state !== 3'd0 || {busy, err, done, store_wen, store_elem_valid, rand_req, elem_cnt,
        store_m, store_n, store_elem} !== '0) begin
      fails++; $display("FAIL midreset got st %0d or outputs nonzero, want all 0", state);
    end
    tick();
    s0 = strobe_seen; w0 = wen_seen;
    for (int i = 0; i < 6; i++) begin
      pulse_confirm(8'd3); tick();
    end
    checks++;
    if (state !== 3'd0 || strobe_seen != s0 || wen_seen != w0) begin
      fails++; $display("FAIL midreset_quiet got st %0d strb %0d wen %0d want 0/0/0",
                        state, strobe_seen - s0, wen_seen - w0);
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_dim_error();
    test_confirm_finish();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
